// File: rtl/cdp_dec_sync.sv
// Priority-index decoder with input FIFO and per-word output hold.
// Index 0 maps to the MSB of out, mirroring the upstream encoder.
module cdp_dec_sync #(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IDX_W-1:0]          in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [(2**IDX_W)-1:0]     out,
  output logic                      valid,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int OUT_W = 2**IDX_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count_n;
  logic [HW-1:0]      hcnt, hcnt_n;
  logic [OUT_W-1:0]   out_n;
  logic               valid_n;
  logic               push, pop, empty;

  function automatic logic [OUT_W-1:0] dec(
    input logic [IDX_W-1:0] i
  );
    logic [OUT_W-1:0] msb;
    msb = {1'b1, {(OUT_W-1){1'b0}}};
    return msb >> i;
  endfunction

  assign ready_out = (count < CW'(DEPTH));
  assign push      = valid_in & ready_out;
  assign empty     = (count == '0);

  always_comb begin
    pop     = 1'b0;
    state_n = state;
    hcnt_n  = hcnt;
    out_n   = out;
    valid_n = valid;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          out_n   = dec(mem[rd_ptr]);
          valid_n = 1'b1;
          hcnt_n  = HW'(HOLD - 1);
          state_n = S_HOLD;
        end else begin
          out_n   = '0;
          valid_n = 1'b0;
        end
      end
      S_HOLD: begin
        if (hcnt != '0) begin
          hcnt_n = hcnt - HW'(1);
        end else if (!empty) begin
          // next word follows with no idle gap
          pop     = 1'b1;
          out_n   = dec(mem[rd_ptr]);
          valid_n = 1'b1;
          hcnt_n  = HW'(HOLD - 1);
        end else begin
          out_n   = '0;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: begin
        out_n   = '0;
        valid_n = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hcnt   <= '0;
      out    <= '0;
      valid  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      hcnt  <= hcnt_n;
      out   <= out_n;
      valid <= valid_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

endmodule

// File: tb/tb_cdp_dec_sync.sv
// Directed bench for cdp_dec_sync: vector table plus
// hand sequences for hold, backpressure and reset.
module tb_cdp_dec_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // a: defaults (HOLD=1)
  logic [1:0] a_in = '0;
  logic       a_v = 1'b0;
  logic       a_rdy, a_val;
  logic [3:0] a_out;
  logic [2:0] a_cnt;
  // b: 8-wide, HOLD=4, DEPTH=4
  logic [2:0] b_in = '0;
  logic       b_v = 1'b0;
  logic       b_rdy, b_val;
  logic [7:0] b_out;
  logic [2:0] b_cnt;
  // c: HOLD=3
  logic [1:0] c_in = '0;
  logic       c_v = 1'b0;
  logic       c_rdy, c_val;
  logic [3:0] c_out;
  logic [2:0] c_cnt;

  cdp_dec_sync u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .valid_in(a_v),
    .ready_out(a_rdy), .out(a_out), .valid(a_val), .count(a_cnt)
  );
  cdp_dec_sync #(.IDX_W(3), .DEPTH(4), .HOLD(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .valid_in(b_v),
    .ready_out(b_rdy), .out(b_out), .valid(b_val), .count(b_cnt)
  );
  cdp_dec_sync #(.HOLD(3)) u_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .valid_in(c_v),
    .ready_out(c_rdy), .out(c_out), .valid(c_val), .count(c_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] enc(input logic [3:0] e);
    logic [2:0] r;
    r = 3'b000;
    if (e[3])      r = 3'b100;
    else if (e[2]) r = 3'b101;
    else if (e[1]) r = 3'b110;
    else if (e[0]) r = 3'b111;
    return r;
  endfunction

  typedef struct {
    logic       v;
    logic [1:0] in;
    logic [3:0] eout;
    logic       eval;
    logic [2:0] ecnt;
    logic       erdy;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic [3:0] e_in[7];
    logic [3:0] e_out[7];
    logic [2:0] e_cnt[7];
    logic [2:0] e;
    logic [3:0] c_exp;
    logic [7:0] b_exp;
    logic       b_ev, acc;
    int         wi;
    int         acc_edge[6];

    tv[0] = '{1'b1, 2'b10, 4'b0000, 1'b0, 3'd1, 1'b1};
    tv[1] = '{1'b0, 2'b00, 4'b0010, 1'b1, 3'd0, 1'b1};
    tv[2] = '{1'b0, 2'b00, 4'b0000, 1'b0, 3'd0, 1'b1};
    tv[3] = '{1'b1, 2'b00, 4'b0000, 1'b0, 3'd1, 1'b1};
    tv[4] = '{1'b1, 2'b01, 4'b1000, 1'b1, 3'd1, 1'b1};
    tv[5] = '{1'b1, 2'b10, 4'b0100, 1'b1, 3'd1, 1'b1};
    tv[6] = '{1'b1, 2'b11, 4'b0010, 1'b1, 3'd1, 1'b1};
    tv[7] = '{1'b0, 2'b00, 4'b0001, 1'b1, 3'd0, 1'b1};
    tv[8] = '{1'b0, 2'b00, 4'b0000, 1'b0, 3'd0, 1'b1};

    // asynchronous reset, no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({a_val, a_out, a_cnt, a_rdy}),
        32'({1'b0, 4'b0000, 3'd0, 1'b1}));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      a_v = tv[i].v;
      a_in = tv[i].in;
      step();
      chk($sformatf("vec%0d", i),
          32'({a_val, a_out, a_cnt, a_rdy}),
          32'({tv[i].eval, tv[i].eout, tv[i].ecnt, tv[i].erdy}));
    end
    a_v = 1'b0;

    // round trip through an encoder model
    e_in  = '{4'b1010, 4'b0110, 4'b0011, 4'b0001,
              4'b0000, 4'b0000, 4'b0000};
    e_out = '{4'b0000, 4'b1000, 4'b0100, 4'b0010,
              4'b0001, 4'b0000, 4'b0000};
    e_cnt = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 7; i++) begin
      e = enc(e_in[i]);
      a_v = e[2];
      a_in = e[1:0];
      step();
      chk($sformatf("rt%0d", i), 32'({a_val, a_out, a_cnt}),
          32'({(e_out[i] != 4'b0000), e_out[i], e_cnt[i]}));
    end
    a_v = 1'b0;

    // HOLD=3, two words back to back
    for (int k = 1; k <= 9; k++) begin
      c_v = (k <= 2);
      c_in = (k == 1) ? 2'b01 : 2'b11;
      step();
      if (k >= 2 && k <= 4)      c_exp = 4'b0100;
      else if (k >= 5 && k <= 7) c_exp = 4'b0001;
      else                       c_exp = 4'b0000;
      chk($sformatf("hold3_%0d", k), 32'({c_val, c_out}),
          32'({(c_exp != 4'b0000), c_exp}));
    end
    c_v = 1'b0;

    // reset while holding with two entries queued
    for (int k = 0; k < 3; k++) begin
      b_v = 1'b1;
      b_in = 3'(k);
      step();
    end
    b_v = 1'b0;
    chk("pre_rst", 32'({b_val, b_out, b_cnt}),
        32'({1'b1, 8'h80, 3'd2}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({b_val, b_out, b_cnt, b_rdy}),
        32'({1'b0, 8'h00, 3'd0, 1'b1}));
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("post_rst%0d", k), 32'({b_val, b_out, b_cnt}),
          32'({1'b0, 8'h00, 3'd0}));
    end

    // backpressure: six words, HOLD=4, DEPTH=4
    wi = 0;
    for (int k = 0; k < 6; k++) acc_edge[k] = -1;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      b_v = (wi < 6);
      b_in = 3'(wi);
      acc = b_v && b_rdy;
      step();
      if (acc) begin
        acc_edge[wi] = cyc;
        wi++;
      end
      b_ev = (cyc >= 2 && cyc <= 25);
      b_exp = b_ev ? (8'h80 >> ((cyc - 2) / 4)) : 8'h00;
      chk($sformatf("bp_out%0d", cyc), 32'({b_val, b_out}),
          32'({b_ev, b_exp}));
      if (cyc == 5)
        chk("bp_full", 32'({b_cnt, b_rdy}), 32'({3'd4, 1'b0}));
      if (cyc == 6)
        chk("bp_pop", 32'({b_cnt, b_rdy}), 32'({3'd3, 1'b1}));
    end
    b_v = 1'b0;
    for (int k = 0; k < 6; k++)
      chk($sformatf("acc_w%0d", k + 1), 32'(acc_edge[k]),
          32'((k < 5) ? k + 1 : 7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdp_dec_sync.md
Name: cdp_dec_sync

Overview:
- Synchronous decoder for the priority-encoder interface: takes a 2-bit priority index plus valid and expands it back to a one-hot vector.
- Uses the same index mapping as the encoder, so that index 0 selects the MSB.
- Sits downstream of the priority encoder. A small FIFO absorbs bursts, and each decoded one-hot word is held on the output for a programmable number of cycles.
- Backpressures the encoder side through a ready signal.

Parameters:
- IDX_W, 2, index width. Output width is OUT_W = 2**IDX_W (4 at default).
- DEPTH, 4, FIFO entries. Power of two, at least 2.
- HOLD, 1, cycles each decoded word stays on out. Must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  IDX_W  encoded priority index.
- valid_in  input  1  in carries a valid index.
- ready_out  output  1  block can accept; a transfer occurs on a rising edge with valid_in=1 and ready_out=1.
- out  output  OUT_W  decoded one-hot word, registered.
- valid  output  1  out holds a decoded word, registered.
- count  output  clog2(DEPTH)+1  FIFO occupancy, registered.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - While rst_n=0: out=0, valid=0, count=0, FIFO pointers=0, FSM=IDLE, hold counter=0.
  - ready_out=1 as soon as rst_n deasserts.
  - Reset mid-operation discards FIFO contents and any word being held.
- Decode mapping: out[OUT_W-1-in]=1, all other bits 0. Default values: 00->1000, 01->0100, 10->0010, 11->0001. This is the exact inverse of the encoder.
- Input side:
  - ready_out = (count < DEPTH), combinational from registered count.
  - When valid_in=1 and ready_out=1, in is written at the write pointer and the write pointer increments, wrapping modulo DEPTH.
  - When valid_in=1 and ready_out=0, nothing is written. Upstream must hold in/valid_in stable until accepted.
- FIFO pop/push:
  - A pop reads at the read pointer and increments it, wrapping.
  - Push and pop on the same edge leave count unchanged.
  - When full, push is blocked even if a pop occurs on that edge (ready_out is from the pre-edge count).
- Output FSM, states IDLE and HOLD:
  - IDLE, FIFO non-empty: pop, load out=decode(head), valid=1, hold counter=HOLD-1, go to HOLD.
  - IDLE, FIFO empty: out=0, valid=0, stay in IDLE.
  - HOLD, hold counter>0: decrement the counter; out and valid unchanged.
  - HOLD, hold counter=0, FIFO non-empty: pop and load the next word immediately, with no idle gap. Counter reloads to HOLD-1; stay in HOLD.
  - HOLD, hold counter=0, FIFO empty: out=0, valid=0, go to IDLE.
- Empty FIFO: a pop is never performed when empty.
  - Latency: a word written at edge N into an empty FIFO with FSM in IDLE appears on out after edge N+1.
  - The FIFO is not bypassed.
- Each word occupies out for exactly HOLD cycles. A sustained stream produces back-to-back words with valid continuously 1.
- An index equal to an all-zero encoder output is decoded like any other value. Upstream only asserts valid_in when the encoder's valid=1.
- count reflects pushes and pops of the current edge, and reaches DEPTH at most.

Test Plan:
- Reset: rst_n=0 asynchronously with no clk edge -> out=0000, valid=0, count=0, ready_out=1. Repeat while in HOLD with 2 entries queued -> all cleared; after release, out stays 0 with no stale words.
- Single word, HOLD=1: in=2'b10, valid_in=1 for one cycle at edge 1 -> out=0010, valid=1 after edge 2 only; out=0000, valid=0 after edge 3.
- Mapping/back-to-back, HOLD=1: push 00,01,10,11 on consecutive edges -> out=1000,0100,0010,0001 on 4 consecutive cycles with valid continuously 1, then 0.
- Full/backpressure, HOLD=4, DEPTH=4, valid_in held high with 6 distinct words:
  - Words 1-5 are accepted; after word 5, count=4 and ready_out=0.
  - Word 6 is held and accepted on the first edge after word 2 is popped.
  - Output order is 1..6 with each word held 4 cycles.
- Hold timing, HOLD=3: two words pushed back-to-back -> word A for 3 cycles, then word B for 3 cycles, no gap, then valid=0.
- Round-trip: drive encoder inputs 1xxx, 01xx, 001x, 0001 through the encoder into this block -> out=1000, 0100, 0010, 0001, in order. Encoder input 0000 (valid=0) produces no push.
